// File: rtl/prog_timer_if.sv
// Command/status bundle for one prog_timer channel.
// timer_ovr exists only when PROG_TIMER_OVERRUN_EN is defined.
interface prog_timer_if #(
    parameter int TIME_W = 10
);
    logic              timer_load;
    logic [TIME_W-1:0] timer_data;
    logic              timer_mode;
    logic              timer_start;
    logic              timer_stop;
    logic              timer_clr;
    logic              timer_out;
    logic              timer_pulse;
    logic              timer_busy;
    logic [TIME_W-1:0] timer_count;
`ifdef PROG_TIMER_OVERRUN_EN
    logic              timer_ovr;

    modport master (
        output timer_load, timer_data, timer_mode, timer_start, timer_stop, timer_clr,
        input  timer_out, timer_pulse, timer_busy, timer_count, timer_ovr
    );
    modport slave (
        input  timer_load, timer_data, timer_mode, timer_start, timer_stop, timer_clr,
        output timer_out, timer_pulse, timer_busy, timer_count, timer_ovr
    );
`else
    modport master (
        output timer_load, timer_data, timer_mode, timer_start, timer_stop, timer_clr,
        input  timer_out, timer_pulse, timer_busy, timer_count
    );
    modport slave (
        input  timer_load, timer_data, timer_mode, timer_start, timer_stop, timer_clr,
        output timer_out, timer_pulse, timer_busy, timer_count
    );
`endif
endinterface

// File: rtl/prog_timer.sv
// Programmable prescaled down-counting timer: one-shot / periodic, pause/resume,
// expiry pulse + sticky flag. PROG_TIMER_OVERRUN_EN adds the timer_ovr missed-service flag.
module prog_timer #(
    parameter int PRESCALE = 5,
    parameter int TIME_W   = 10,
    parameter int PRE_W    = 3
) (
    input  logic         timer_clock,
    input  logic         timer_rstn,
    prog_timer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

    state_t            state, state_nxt;
    logic [TIME_W-1:0] cnt, cnt_nxt;
    logic [TIME_W-1:0] reload, reload_nxt;
    logic [PRE_W-1:0]  pre, pre_nxt;
    logic              mode_r, mode_nxt;
    logic              out_q, out_nxt;
    logic              pulse_q, pulse_nxt;
    logic              busy_q, busy_nxt;
    logic              expire;
    logic [TIME_W-1:0] start_cnt;

    always_ff @(posedge timer_clock or negedge timer_rstn) begin
        if (!timer_rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            reload  <= '0;
            pre     <= '0;
            mode_r  <= 1'b0;
            out_q   <= 1'b0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            reload  <= reload_nxt;
            pre     <= pre_nxt;
            mode_r  <= mode_nxt;
            out_q   <= out_nxt;
            pulse_q <= pulse_nxt;
            busy_q  <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        reload_nxt = reload;
        pre_nxt    = pre;
        mode_nxt   = mode_r;
        expire     = 1'b0;
        start_cnt  = (state == DONE) ? reload : cnt;

        if (bus.timer_load) begin
            reload_nxt = bus.timer_data;
            cnt_nxt    = bus.timer_data;
            pre_nxt    = '0;
            state_nxt  = IDLE;
        end else if (state == RUN) begin
            if (bus.timer_stop) begin
                state_nxt = PAUSE;
            end else if (pre == PRE_MAX) begin
                pre_nxt = '0;
                if (cnt > TIME_W'(1)) begin
                    cnt_nxt = cnt - TIME_W'(1);
                end else begin
                    expire = 1'b1;
                    if (mode_r) begin
                        cnt_nxt = reload;
                    end else begin
                        cnt_nxt   = '0;
                        state_nxt = DONE;
                    end
                end
            end else begin
                pre_nxt = pre + PRE_W'(1);
            end
        end else if (bus.timer_start && !bus.timer_stop) begin
            // stop outranks start even where stop itself has no effect
            mode_nxt = bus.timer_mode;
            if (start_cnt == '0) begin
                // zero count expires immediately and parks in DONE in either mode
                expire    = 1'b1;
                cnt_nxt   = '0;
                pre_nxt   = '0;
                state_nxt = DONE;
            end else begin
                cnt_nxt   = start_cnt;
                state_nxt = RUN;
            end
        end

        out_nxt   = expire | (out_q & ~bus.timer_clr & ~bus.timer_load);
        pulse_nxt = expire;
        busy_nxt  = (state_nxt == RUN);
    end

    assign bus.timer_out   = out_q;
    assign bus.timer_pulse = pulse_q;
    assign bus.timer_busy  = busy_q;
    assign bus.timer_count = cnt;

`ifdef PROG_TIMER_OVERRUN_EN
    logic ovr_q;

    always_ff @(posedge timer_clock or negedge timer_rstn) begin
        if (!timer_rstn)
            ovr_q <= 1'b0;
        else if (expire && out_q && !bus.timer_clr)
            ovr_q <= 1'b1;
        else if (bus.timer_clr || bus.timer_load)
            ovr_q <= 1'b0;
    end

    assign bus.timer_ovr = ovr_q;
`endif
endmodule
